dm_responder: RTL and testbench

Multi-cycle data-memory responder serving the pipeline CPU's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel. It replaces the zero-latency `dm` behaviour with a configurable-latency word memory, so the CPU's hazard logic can be exercised against real memory stalls. Exactly one transaction is outstanding at a time. Every request, load or store, receives exactly one response.

---
 rtl/dm_responder_pkg.sv | 19 +
 rtl/dm_responder_resp_ram.sv | 29 ++
 rtl/dm_responder.sv | 112 +++++++++++
 tb/tb_dm_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: state encoding, word width
// and the error flag value reported for misaligned accesses.
package dm_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic ERR_MISALIGN = 1'b1;

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dm_responder_resp_ram.sv
// Single-port word array: synchronous write, registered read, no reset.
// The read register only updates on an enabled read, so its value is held between accesses.
module resp_ram
  import dm_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Configurable-latency data-memory responder for the MEM stage: one outstanding
// request, one response per request, misaligned accesses answered with an error.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              rd_sel;
  logic              access;
  logic              cap_write;
  logic              cap_mis;
  logic [AW-1:0]     cap_idx;
  logic [WORD_W-1:0] cap_wdata;
  logic [WORD_W-1:0] ram_q;
  logic              addr_unused;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign addr_unused = ^req_addr[WORD_W-1:AW+2];

  assign access = (state == ST_BUSY) && (cnt == 4'd0);

  // Request capture: data only, qualified by the accept handshake.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && req_valid) begin
      cap_write <= req_write;
      cap_mis   <= is_misaligned(req_addr);
      cap_idx   <= req_addr[AW+1:2];
      cap_wdata <= req_wdata;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_sel     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_BUSY;
            cnt       <= LAT_INIT;
            req_ready <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= cap_mis ? ERR_MISALIGN : 1'b0;
            rd_sel     <= !cap_write && !cap_mis;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

  // Stores and errors report zero; loads expose the registered array read.
  assign resp_rdata = rd_sel ? ram_q : '0;

  resp_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clock(clock),
    .en   (access),
    .we   (cap_write && !cap_mis),
    .addr (cap_idx),
    .wdata(cap_wdata),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder at LATENCY 2, 1 and 15 against a word-addressed
// memory model held in an associative array.
module tb_dm_responder;

  localparam int DEPTH = 1024;
  localparam int LAT [3] = '{2, 1, 15};

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] mdl [int];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  dm_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dm_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  dm_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
  );

  // One full transaction on instance i; hold = cycles resp_ready stays low once valid.
  task automatic txn(input int i, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, input string tag,
                     output int acc);
    int n;
    int key;
    logic exp_e;
    logic chk_d;
    logic [31:0] exp_d;
    logic [31:0] held;
    key   = i * DEPTH + int'((addr >> 2) % DEPTH);
    exp_e = (addr % 4) != 0;
    chk_d = 1'b1;
    exp_d = 32'h0;
    if (!exp_e && !wr) begin
      if (mdl.exists(key)) exp_d = mdl[key];
      else chk_d = 1'b0;
    end
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(posedge clock); #1; n++;
    end
    n_checks++;
    if (req_ready[i] !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_ready inst%0d: got %b want 1", tag, i, req_ready[i]);
    end
    req_valid[i]  = 1'b1;
    req_write[i]  = wr;
    req_addr[i]   = addr;
    req_wdata[i]  = wd;
    resp_ready[i] = (hold == 0);
    @(posedge clock); #1;
    acc = cyc;
    n = 0;
    while (!resp_valid[i] && n < 40) begin
      n_checks++;
      if (req_ready[i] !== 1'b0) begin
        n_fail++; $display("FAIL %s busy_ready inst%0d: got %b want 0", tag, i, req_ready[i]);
      end
      req_valid[i] = 1'($urandom % 2);
      req_write[i] = 1'($urandom % 2);
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
      @(posedge clock); #1; n++;
    end
    req_valid[i] = 1'b0;
    n_checks++;
    if (n != LAT[i]) begin
      n_fail++; $display("FAIL %s latency inst%0d: got %0d want %0d", tag, i, n, LAT[i]);
    end
    n_checks++;
    if (resp_err[i] !== exp_e) begin
      n_fail++; $display("FAIL %s err inst%0d: got %b want %b", tag, i, resp_err[i], exp_e);
    end
    if (chk_d) begin
      n_checks++;
      if (resp_rdata[i] !== exp_d) begin
        n_fail++; $display("FAIL %s rdata inst%0d: got %h want %h", tag, i, resp_rdata[i], exp_d);
      end
    end
    held = resp_rdata[i];
    for (int h = 0; h < hold; h++) begin
      req_valid[i] = 1'($urandom % 2);
      req_write[i] = 1'($urandom % 2);
      req_addr[i]  = $urandom;
      @(posedge clock); #1;
      n_checks++;
      if (resp_valid[i] !== 1'b1 || resp_rdata[i] !== held || req_ready[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold inst%0d: got valid=%b rdata=%h ready=%b want 1 %h 0",
                 tag, i, resp_valid[i], resp_rdata[i], req_ready[i], held);
      end
    end
    req_valid[i]  = 1'b0;
    resp_ready[i] = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (req_ready[i] !== 1'b1 || resp_valid[i] !== 1'b0 || resp_err[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_hs inst%0d: got ready=%b valid=%b err=%b want 1 0 0",
               tag, i, req_ready[i], resp_valid[i], resp_err[i]);
    end
    resp_ready[i] = 1'b0;
    if (wr && !exp_e) mdl[key] = wd;
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    n_checks++;
    if (req_ready[i] !== 1'b1 || resp_valid[i] !== 1'b0 ||
        resp_err[i] !== 1'b0 || resp_rdata[i] !== 32'h0) begin
      n_fail++;
      $display("FAIL %s inst%0d: got ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
               tag, i, req_ready[i], resp_valid[i], resp_err[i], resp_rdata[i]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; resp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset_state");
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_store_load();
    int acc;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, "store10", acc);
    txn(0, 1'b0, 32'h10, 32'h0, 0, "load10", acc);
    txn(0, 1'b0, 32'h10 + 4 * DEPTH, 32'h0, 0, "load_alias", acc);
  endtask

  task automatic test_misaligned();
    int acc;
    txn(0, 1'b1, 32'h13, 32'hCAFEF00D, 0, "store13", acc);
    txn(0, 1'b0, 32'h12, 32'h0, 1, "load12", acc);
    txn(0, 1'b0, 32'h10, 32'h0, 0, "load10_post_mis", acc);
  endtask

  task automatic test_backpressure();
    int acc;
    txn(0, 1'b0, 32'h10, 32'h0, 5, "bp_load", acc);
  endtask

  task automatic test_reset_midbusy();
    int acc;
    txn(0, 1'b1, 32'h20, 32'h0, 0, "pre_store20", acc);
    txn(0, 1'b0, 32'h10, 32'h0, 0, "pre_load10", acc);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    resp_ready[0] = 1'b0;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    n_checks++;
    if (req_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL midbusy_accept: got ready=%b want 0", req_ready[0]);
    end
    reset = 1'b1;
    #1;
    check_idle_outputs(0, "reset_midbusy");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 0, "load20_dropped", acc);
  endtask

  task automatic test_random();
    int acc;
    logic [31:0] a;
    for (int t = 0; t < 40; t++) begin
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)) * 4 * DEPTH;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      txn(0, 1'($urandom % 2), a, $urandom, $urandom_range(0, 3), "rand", acc);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int prev;
    logic [31:0] a;
    for (int i = 1; i < 3; i++) begin
      txn(i, 1'b1, 32'h40, 32'hA5A50000 + 32'(i), 0, "b2b_seed", prev);
      for (int t = 0; t < 6; t++) begin
        a = 32'h40 + 32'($urandom_range(0, 1)) * 4;
        txn(i, 1'($urandom % 2), a, $urandom, 0, "b2b", acc);
        n_checks++;
        if (acc - prev != LAT[i] + 2) begin
          n_fail++;
          $display("FAIL b2b_interval inst%0d: got %0d want %0d", i, acc - prev, LAT[i] + 2);
        end
        prev = acc;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_backpressure();
    test_reset_midbusy();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
